// File: rtl/mips_mmio_mem.sv
// mips_mmio_mem: data memory plus memory-mapped I/O for the MIPS memory stage.
// The address selects word RAM, a 256-byte I/O register window, or unmapped
// space. Reads have one cycle of latency; err pulses one cycle after a bad access.
module mips_mmio_mem #(
  parameter int WIDTH      = 32,
  parameter int RAM_AWIDTH = 8,
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 1,
  parameter logic [WIDTH-1:0] IO_BASE = WIDTH'(32'h0000FF00)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [NUM_IN-1:0]        in_en,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WIDTH/8-1:0]       byte_en,
  input  logic [WIDTH-1:0]         addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [NUM_OUT*WIDTH-1:0] out_port,
  output logic                     err
);
  localparam int NB = WIDTH / 8;

  // Read-data source selected for the cycle after a read
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_IO   = 2'd2;

  logic [WIDTH-1:0] ram [2**RAM_AWIDTH];
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] io_q;
  logic [WIDTH-1:0] io_rdata;
  logic [1:0]       rd_sel;

  logic [WIDTH-1:0] in_port  [NUM_IN];
  logic [WIDTH-1:0] out_reg  [NUM_OUT];
  logic [NUM_IN-1:0] status;

  logic [5:0]            idx;
  logic [RAM_AWIDTH-1:0] ram_idx;
  logic in_ram, in_io, io_hit, idx_in, idx_stat, idx_out;
  logic bad, rd_ok, wr_ok, ram_we, ram_re, io_re, out_we, stat_clr;

  assign idx      = addr[7:2];
  assign ram_idx  = addr[RAM_AWIDTH+1:2];
  assign in_ram   = (addr[WIDTH-1:RAM_AWIDTH+2] == '0);
  assign in_io    = (addr[WIDTH-1:8] == IO_BASE[WIDTH-1:8]);
  // RAM takes priority should a parameter choice make the regions overlap
  assign io_hit   = in_io && !in_ram;
  assign idx_in   = (idx < 6'(NUM_IN));
  assign idx_stat = (idx == 6'd63);
  assign idx_out  = (idx >= 6'd32) && (idx < 6'(32 + NUM_OUT));

  // A bad access suppresses both halves of a combined read/write
  assign bad = (mem_read || mem_write) &&
               ((addr[1:0] != 2'b00) || !(in_ram || in_io) ||
                (mem_write && io_hit && (idx_in || idx_stat)));

  assign rd_ok    = mem_read  && !bad;
  assign wr_ok    = mem_write && !bad;
  assign ram_re   = rd_ok && in_ram;
  assign ram_we   = wr_ok && in_ram;
  assign io_re    = rd_ok && io_hit;
  assign out_we   = wr_ok && io_hit && idx_out;
  assign stat_clr = io_re && idx_stat;

  // I/O read mux over the register window; unused indices read zero
  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (idx == 6'(i)) io_rdata = in_port[i];
    for (int k = 0; k < NUM_OUT; k++)
      if (idx == 6'(32 + k)) io_rdata = out_reg[k];
    if (idx_stat) io_rdata = WIDTH'(status);
  end

  // Synchronous RAM: the read port registers the pre-write word
  always_ff @(posedge clk) begin
    if (ram_re) ram_q <= ram[ram_idx];
    if (ram_we)
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) ram[ram_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end

  // Input capture and sticky change flags; a capture on this edge beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) in_port[i] <= '0;
      status <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_en[i]) in_port[i] <= in_data;
        if (in_en[i] && (in_data != in_port[i])) status[i] <= 1'b1;
        else if (stat_clr)                        status[i] <= 1'b0;
      end
    end
  end

  // Output port registers with per-lane write enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) out_reg[k] <= '0;
    end else if (out_we) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (idx == 6'(32 + k))
          for (int b = 0; b < NB; b++)
            if (byte_en[b]) out_reg[k][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Read strobe, error pulse, source select and I/O snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rd_sel   <= SEL_ZERO;
      io_q     <= '0;
    end else begin
      rd_valid <= mem_read;
      err      <= bad;
      rd_sel   <= ram_re ? SEL_RAM : (io_re ? SEL_IO : SEL_ZERO);
      if (io_re) io_q <= io_rdata;
    end
  end

  assign rd_data = (rd_sel == SEL_RAM) ? ram_q :
                   (rd_sel == SEL_IO)  ? io_q  : '0;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_port[k*WIDTH +: WIDTH] = out_reg[k];
  end
endmodule

// File: tb/tb_mips_mmio_mem.sv
// Bench for mips_mmio_mem: directed walk through the main scenarios followed by
// random traffic, all checked against an address-map model held in the bench.
module tb_mips_mmio_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_en;
  logic        mem_read, mem_write;
  logic [3:0]  byte_en;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] out_port;
  logic        err;

  mips_mmio_mem dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
    .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .out_port(out_port), .err(err)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_ram [256];
  logic [31:0] m_out;
  logic [31:0] m_in [2];
  logic [1:0]  m_stat;
  logic [31:0] last_rd;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One bus cycle: drive, predict from the model, clock, check, update model
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [1:0] ie, input logic [31:0] id);
    logic        is_ram, is_io, is_bad;
    logic [5:0]  ix;
    logic [31:0] e_rd;
    logic [1:0]  n_stat;
    @(negedge clk);
    mem_read = r; mem_write = w; addr = a; byte_en = be; wr_data = wd;
    in_en = ie; in_data = id;
    is_ram = (a < 32'd1024);
    is_io  = (a[31:8] == 24'h0000FF);
    ix     = a[7:2];
    is_bad = (r || w) && ((a[1:0] != 2'b00) || (!is_ram && !is_io) ||
             (w && is_io && (ix < 6'd2 || ix == 6'd63)));
    e_rd = 32'h0;
    if (r && !is_bad) begin
      if (is_ram) e_rd = m_ram[a[9:2]];
      else if (ix < 6'd2) e_rd = m_in[ix[0]];
      else if (ix == 6'd32) e_rd = m_out;
      else if (ix == 6'd63) e_rd = {30'h0, m_stat};
    end
    n_stat = (r && !is_bad && is_io && ix == 6'd63) ? 2'b00 : m_stat;
    for (int i = 0; i < 2; i++) begin
      if (ie[i] && id != m_in[i]) n_stat[i] = 1'b1;
      if (ie[i]) m_in[i] = id;
    end
    m_stat = n_stat;
    if (w && !is_bad) begin
      if (is_ram) m_ram[a[9:2]] = merge(m_ram[a[9:2]], wd, be);
      else if (ix == 6'd32) m_out = merge(m_out, wd, be);
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'h0, rd_valid}, {31'h0, r});
    chk("rd_data", rd_data, e_rd);
    chk("err", {31'h0, err}, {31'h0, is_bad});
    chk("out_port", out_port, m_out);
    last_rd = rd_data;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'b00, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [5:0]  ix;
    int          kind;
    rst = 1'b1; in_data = '0; in_en = '0; mem_read = 0; mem_write = 0;
    byte_en = '0; addr = '0; wr_data = '0;
    m_out = '0; m_in[0] = '0; m_in[1] = '0; m_stat = '0;
    #12;
    chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_out_port", out_port, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill RAM so every model word is known
    for (int i = 0; i < 256; i++)
      step(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, 2'b00, 32'h0);

    // Input port 0 after reset
    step(1'b1, 1'b0, 32'h0000FF00, 4'h0, 32'h0, 2'b00, 32'h0);
    idle();
    // Capture on port 1, read it and the sticky flag, flag clears on read
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'b10, 32'h1234);
    step(1'b1, 1'b0, 32'h0000FF04, 4'h0, 32'h0, 2'b00, 32'h0);
    chk("in_port1_literal", last_rd, 32'h1234);
    step(1'b1, 1'b0, 32'h0000FFFC, 4'h0, 32'h0, 2'b00, 32'h0);
    chk("status_literal", last_rd, 32'h2);
    step(1'b1, 1'b0, 32'h0000FFFC, 4'h0, 32'h0, 2'b00, 32'h0);
    chk("status_cleared", last_rd, 32'h0);
    // Byte-lane RAM write
    step(1'b0, 1'b1, 32'h10, 4'hF, 32'hAABBCCDD, 2'b00, 32'h0);
    step(1'b0, 1'b1, 32'h10, 4'b0001, 32'h00000011, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 2'b00, 32'h0);
    chk("ram_bytelane_literal", last_rd, 32'hAABBCC11);
    // Output port write and readback
    step(1'b0, 1'b1, 32'h0000FF80, 4'hF, 32'hCAFEF00D, 2'b00, 32'h0);
    chk("out_port_literal", out_port, 32'hCAFEF00D);
    step(1'b1, 1'b0, 32'h0000FF80, 4'h0, 32'h0, 2'b00, 32'h0);
    // Error cases
    step(1'b0, 1'b1, 32'h0000FF00, 4'hF, 32'h5, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h0000FF00, 4'h0, 32'h0, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h0000FF02, 4'h0, 32'h0, 2'b00, 32'h0);
    step(1'b0, 1'b1, 32'h00010000, 4'hF, 32'hDEADBEEF, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 2'b00, 32'h0);
    // Read-during-write returns the old word; byte_en=0 is a no-op
    step(1'b1, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 2'b00, 32'h0);
    step(1'b1, 1'b1, 32'h20, 4'h0, 32'h12345678, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 2'b00, 32'h0);
    // Capture on the same edge as a STATUS read: set wins
    step(1'b1, 1'b0, 32'h0000FFFC, 4'h0, 32'h0, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h0000FFFC, 4'h0, 32'h0, 2'b01, 32'h77);
    step(1'b1, 1'b0, 32'h0000FFFC, 4'h0, 32'h0, 2'b00, 32'h0);
    chk("status_set_wins", last_rd, 32'h1);
    // Back-to-back mixed reads
    step(1'b1, 1'b0, 32'h0000FF80, 4'h0, 32'h0, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h0000FF10, 4'h0, 32'h0, 2'b00, 32'h0);
    idle();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      kind = $urandom_range(0, 9);
      ix = 6'd0;
      case ($urandom_range(0, 5))
        0: ix = 6'd0;  1: ix = 6'd1;  2: ix = 6'd32;
        3: ix = 6'd63; 4: ix = 6'd5;  default: ix = 6'd40;
      endcase
      if (kind < 4)       a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      else if (kind < 7)  a = {24'h0000FF, ix, 2'b00};
      else if (kind == 7) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (kind == 8) a = 32'h00010000 + {$urandom_range(0, 255), 2'b00};
      else                a = {24'h0000FF, ix, 2'($urandom_range(1, 3))};
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
           4'($urandom), $urandom, 2'($urandom), 32'($urandom_range(0, 3)));
    end
    idle();

    // Reset while a read is pending
    step(1'b0, 1'b1, 32'h0000FF80, 4'hF, 32'h13572468, 2'b00, 32'h0);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0000FF80;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_out_port", out_port, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_out = '0; m_in[0] = '0; m_in[1] = '0; m_stat = '0;
    step(1'b1, 1'b0, 32'h0000FF80, 4'h0, 32'h0, 2'b00, 32'h0);
    step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 2'b00, 32'h0);
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mips_mmio_mem.md
# mips_mmio_mem

Parametrised data-memory and memory-mapped I/O unit for the MIPS datapath. It sits between the datapath memory stage and the board I/O, and decodes each access to one of three regions: word-addressed RAM, an I/O register window, or unmapped space. It provides multiple input and output ports, byte-enable writes, sticky input-change flags, output-port readback and a registered read-valid strobe. Read latency is one cycle, the same as the single-port predecessor.

## Interface
- WIDTH, 32, data/address width; must be a multiple of 8.
- RAM_AWIDTH, 8, RAM word-address bits; depth is 2**RAM_AWIDTH words.
- NUM_IN, 2, number of input ports, 1..32.
- NUM_OUT, 1, number of output ports, 1..31.
- IO_BASE, 32'h0000FF00, base of the 256-byte I/O window; low 8 bits must be 0.

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_data  in  WIDTH  shared input-port capture data (e.g. zero-extended switches)
- in_en  in  NUM_IN  per-port capture enable
- mem_read  in  1  read request, single-cycle
- mem_write  in  1  write request, single-cycle
- byte_en  in  WIDTH/8  write byte lanes; bit i covers data[8i+7:8i]
- addr  in  WIDTH  byte address
- wr_data  in  WIDTH  write data
- rd_data  out  WIDTH  read data, valid when rd_valid=1
- rd_valid  out  1  one-cycle pulse, one cycle after mem_read
- out_port  out  NUM_OUT*WIDTH  output port registers; port k is bits [k*WIDTH +: WIDTH]
- err  out  1  one-cycle pulse, one cycle after an erroneous access

## Operation
- Decode (combinational on addr):
  - RAM region: addr[WIDTH-1:RAM_AWIDTH+2]==0. The RAM index is addr[RAM_AWIDTH+1:2].
  - IO region: addr[WIDTH-1:8]==IO_BASE[WIDTH-1:8]. The register index is idx=addr[7:2].
  - Any other address is unmapped.
- I/O map:
  - idx 0..NUM_IN-1: input port idx, read-only.
  - idx 32..32+NUM_OUT-1: output port idx-32, read/write. Reads return the current register value.
  - idx 63: STATUS, read-only. Bit i is the sticky change flag of input port i. Upper bits read 0.
  - Any other idx: reads return 0 and writes are dropped. This is not an error.
- Error (err pulse, access suppressed) occurs on any of:
  - addr[1:0]!=0;
  - an unmapped address;
  - a write to an input-port or STATUS index.
  - A suppressed read still pulses rd_valid, with rd_data=0.
- Input capture: when in_en[i]=1, in_port[i]<=in_data on the clock edge. STATUS[i] is set if the new value differs from the old one.
- STATUS clear: a valid read of STATUS clears every bit on the same edge, except bits set by a capture on that same edge. Set wins over clear.
- RAM: inferred synchronous array, contents not reset.
  - Writes apply byte_en per lane; byte_en=0 is a legal no-op with no error.
  - Read-during-write to the same word returns the OLD word.
- Output ports: a write updates the lanes selected by byte_en.
- mem_read and mem_write both high in the same cycle is legal: the write is performed and the read returns the pre-write value.

## Timing
- Reset values: out_port=0, in_port=0, STATUS=0, rd_data=0, rd_valid=0, err=0. The internal read-select register resets to its zero source.
- Read: mem_read sampled at edge N gives rd_data and rd_valid=1 during cycle N+1. With no new read, rd_valid=0 and rd_data=0 in the following cycle.
- Back-to-back reads are accepted every cycle, each returning data one cycle later.
- I/O read values are snapshotted at edge N. A capture on edge N is not visible until a read sampled at edge N+1.
- Writes commit at the edge where mem_write=1. out_port changes immediately after that edge.
- err is registered and asserts in the cycle after the offending request.
- rst asserted mid-access forces all outputs to their reset values immediately and drops any pending rd_valid. RAM contents are undefined only if reset overlaps the write edge.

## Test plan
- Reset, then read addr 0x0000FF00 with in_en=0 -> rd_valid=1 the next cycle with rd_data=0; err=0.
- in_data=0x1234, in_en=2'b10, then read 0xFF04 -> 0x1234. Read 0xFFFC -> 0x2. Read 0xFFFC again -> 0x0.
- Write 0xAABBCCDD to RAM 0x10 with byte_en=4'hF, then write 0x00000011 with byte_en=4'b0001 -> reading 0x10 returns 0xAABBCC11, one cycle after mem_read.
- Write 0xCAFEF00D to 0xFF80 -> out_port[31:0]=0xCAFEF00D after the edge; a read of 0xFF80 returns the same value.
- Error cases:
  - Write 0x5 to 0xFF00 -> err pulse, in_port unchanged.
  - Read 0x0000FF02 -> err pulse, rd_data=0.
  - Write to 0x00010000 -> err pulse, no RAM change.
- Capture on port 0 with a changed value on the same edge as a STATUS read -> the read returns the old STATUS, and STATUS[0]=1 afterwards. Asserting rst during a pending read -> rd_valid=0 and out_port=0.
